// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry adder: chunk width and configuration legality.
package adder_pkg;

    function automatic int unsigned chunk_w(input int unsigned n, input int unsigned stages);
        return (stages == 0) ? n : n / stages;
    endfunction

    // True when n splits evenly into 1..n stages.
    function automatic bit cfg_ok(input int unsigned n, input int unsigned stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple of one-bit full adders; also exposes the carry into the MSB.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] cy;

    always_comb begin
        cy    = '0;
        sum   = '0;
        cy[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            sum[i]  = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = cy[W];
    assign cmsb = cy[W-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// N-bit adder split into STAGES registered chunks, carry rippling one chunk per cycle, with a
// valid/ready chain. Define PCA_OVF_EN to add the signed-overflow output.
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef PCA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CHUNK = chunk_w(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : gen_cfg_err
        $error("pipelined_carry_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end

    logic [STAGES-1:0] v_q, c_q, rdy;
    logic [N-1:0]      sum_q [STAGES];
    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      b_q   [STAGES];

    // Per-stage sources: stage 0 takes the ports, stage k takes stage k-1.
    logic [STAGES-1:0] vld_src, c_src;
    logic [N-1:0]      a_src [STAGES];
    logic [N-1:0]      b_src [STAGES];
    logic [N-1:0]      sum_d [STAGES];

    logic [CHUNK-1:0]  ch_sum [STAGES];
    logic [STAGES-1:0] ch_cout, ch_cmsb;

    always_comb begin
        vld_src  = '0;
        c_src    = '0;
        vld_src[0] = in_valid;
        c_src[0]   = cin;
        a_src[0]   = a;
        b_src[0]   = b;
        for (int k = 1; k < int'(STAGES); k++) begin
            vld_src[k] = v_q[k-1];
            c_src[k]   = c_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        chunk_adder #(
            .W (CHUNK)
        ) u_chunk (
            .a    (a_src[k][k*CHUNK +: CHUNK]),
            .b    (b_src[k][k*CHUNK +: CHUNK]),
            .cin  (c_src[k]),
            .sum  (ch_sum[k]),
            .cout (ch_cout[k]),
            .cmsb (ch_cmsb[k])
        );
    end

    always_comb begin
        sum_d[0]              = '0;
        sum_d[0][CHUNK-1:0]   = ch_sum[0];
        for (int k = 1; k < int'(STAGES); k++) begin
            sum_d[k]                    = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK]  = ch_sum[k];
        end
    end

    // rdy[k] = !v[k] | rdy[k+1], unrolled: stage k can load unless it and everything
    // downstream is full while the consumer stalls.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < int'(STAGES); j++) begin
                if (!v_q[j]) rdy[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    v_q[k]   <= vld_src[k];
                    c_q[k]   <= ch_cout[k];
                    sum_q[k] <= sum_d[k];
                    a_q[k]   <= a_src[k];
                    b_q[k]   <= b_src[k];
                end
            end
        end
    end

`ifdef PCA_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (rdy[STAGES-1]) begin
            ovf_q <= ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
        end
    end

    assign ovf = ovf_q;
`endif

    // Operands are fully consumed by the last stage; its copies are never read.
    logic unused_bits;
    assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], ch_cmsb};

    assign in_ready  = rst | rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder; define PCA_OVF_EN to also cover the ovf output.
module tb_pipelined_carry_adder;

    localparam int unsigned N      = 32;
    localparam int unsigned STAGES = 4;
    localparam int unsigned W      = N + 2;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf_obs;
    logic [N-1:0] a, b, sum;

    logic [W-1:0] q[$];
    int           checks = 0;
    int           errors = 0;
    int           pops   = 0;
    int           stalls = 0;
    bit           rnd_done;

    pipelined_carry_adder #(
        .N      (N),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PCA_OVF_EN
        ,
        .ovf       (ovf_obs)
`endif
    );

`ifndef PCA_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ci);
        logic [N:0] s;
        logic       o;
        s = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        o = 1'b0;
`ifdef PCA_OVF_EN
        o = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
`endif
        return {o, s};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on output transfer, push on input transfer, flush on reset.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed=%h expected=none",
                           {ovf_obs, cout, sum});
                end
                if (q.size() != 0) begin
                    chk("result", {ovf_obs, cout, sum}, q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin));
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        bit ok;
        int n;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        ok       = 1'b0;
        n        = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", W'(ok), W'(1));
    endtask

    task automatic measure_latency(input string tag);
        int n;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, W'(n), W'(STAGES));
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0;
        n        = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, W'(q.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int p0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", W'(out_valid), '0);
        chk("reset_result", {ovf_obs, cout, sum}, '0);
        chk("reset_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic add and first-result latency.
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        in_valid = 1'b0;
        measure_latency("basic_latency");
        drain("basic_drain");

        // Full carry chains.
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain("carry_drain");

        // Back-to-back throughput.
        @(posedge clk);
        #1;
        stalls = 0;
        p0     = pops;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain("tput_drain");
        chk("tput_stalls", W'(stalls), '0);
        chk("tput_count", W'(pops - p0), W'(100));

        // Backpressure: fill, hold for 10 cycles, release.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = $urandom;
        b         = $urandom;
        cin       = 1'($urandom_range(0, 1));
        acc       = 0;
        p0        = pops;
        for (int i = 0; i < 10; i++) begin
            bit took;
            @(negedge clk);
            took = in_ready;
            if (took) begin
                acc++;
            end else begin
                chk("stall_valid", W'(out_valid), W'(1));
                chk("stall_hold", {ovf_obs, cout, sum}, q[0]);
            end
            @(posedge clk);
            #1;
            if (took) begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom_range(0, 1));
            end
        end
        chk("stall_accepts", W'(acc), W'(STAGES));
        chk("stall_in_ready", W'(in_ready), '0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("stall_drain");
        chk("stall_count", W'(pops - p0), W'(STAGES));

        // Random consumer backpressure with random input bubbles.
        @(posedge clk);
        #1;
        rnd_done = 1'b0;
        p0       = pops;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 1) == 1);
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("random_drain");
        chk("random_count", W'(pops - p0), W'(1000));

        // Reset with three adds in flight.
        @(posedge clk);
        #1;
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b1);
        send($urandom, $urandom, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_during", W'(in_ready), W'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_result", {ovf_obs, cout, sum}, '0);
        chk("rst_in_ready", W'(in_ready), W'(1));
        p0 = pops;
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        in_valid = 1'b0;
        measure_latency("rst_latency");
        drain("rst_drain");
        chk("rst_count", W'(pops - p0), W'(1));

`ifdef PCA_OVF_EN
        @(posedge clk);
        #1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h0000_0005, 32'h0000_0003, 1'b0);
        drain("ovf_drain");
`endif

        chk("final_queue", W'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
